// File: rtl/config_update_port_if.sv
// Host-side write/readback bus of the configuration update port.
// The design owns the slave modport; the host (or bench) drives the master side.
interface config_update_port_if #(
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic [1:0]        resp_code;
  logic              rd_valid;
  logic [2:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, resp_valid, resp_code, rd_data, rd_data_valid
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, resp_valid, resp_code, rd_data, rd_data_valid
  );
endinterface

// File: rtl/config_update_port.sv
// Shadow/live configuration registers: host writes land in shadows, a validated
// COMMIT copies all three shadows into the live outputs in a single cycle.
//
// state | meaning
// IDLE  | ready for a host request
// EXEC  | decode latched request, update shadows or run commit check
// APPLY | copy shadows to live, pulse cfg_update, bump commit_count
// RESP  | issue the one-cycle response pulse
module config_update_port #(
  parameter int                DATA_W        = 32,
  parameter logic [DATA_W-1:0] DEF_THRESHOLD = DATA_W'(1000),
  parameter logic [DATA_W-1:0] DEF_RISK_MIN  = DATA_W'(1000),
  parameter logic [DATA_W-1:0] DEF_RISK_MAX  = DATA_W'(5000)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  config_update_port_if.slave  bus,
  output logic [DATA_W-1:0]    trading_threshold_o,
  output logic [DATA_W-1:0]    risk_min_o,
  output logic [DATA_W-1:0]    risk_max_o,
  output logic                 cfg_update_o,
  output logic [15:0]          commit_count_o
);

  typedef enum logic [1:0] {IDLE, EXEC, APPLY, RESP} state_t;

  localparam logic [1:0] RESP_OK         = 2'd0;
  localparam logic [1:0] RESP_BAD_ADDR   = 2'd1;
  localparam logic [1:0] RESP_CHECK_FAIL = 2'd2;

  state_t            state_q;
  logic [2:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        pend_code_q;
  logic              resp_valid_q;
  logic [1:0]        resp_code_q;
  logic              cfg_update_q;
  logic [15:0]       commit_count_q;

  logic [DATA_W-1:0] live_thr_q, live_min_q, live_max_q;
  logic [DATA_W-1:0] sh_thr_q, sh_min_q, sh_max_q;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q;

  logic commit_ok;
  assign commit_ok = (sh_min_q <= sh_max_q) && (sh_thr_q != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      pend_code_q    <= RESP_OK;
      resp_valid_q   <= 1'b0;
      resp_code_q    <= RESP_OK;
      cfg_update_q   <= 1'b0;
      commit_count_q <= '0;
      live_thr_q     <= DEF_THRESHOLD;
      live_min_q     <= DEF_RISK_MIN;
      live_max_q     <= DEF_RISK_MAX;
      sh_thr_q       <= DEF_THRESHOLD;
      sh_min_q       <= DEF_RISK_MIN;
      sh_max_q       <= DEF_RISK_MAX;
    end else begin
      resp_valid_q <= 1'b0;
      cfg_update_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.wr_valid) begin
            addr_q  <= bus.wr_addr;
            data_q  <= bus.wr_data;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          state_q     <= RESP;
          pend_code_q <= RESP_OK;
          unique case (addr_q)
            3'd0: sh_thr_q <= data_q;
            3'd1: sh_min_q <= data_q;
            3'd2: sh_max_q <= data_q;
            3'd3: begin
              if (commit_ok) state_q <= APPLY;
              else           pend_code_q <= RESP_CHECK_FAIL;
            end
            3'd4: begin
              sh_thr_q <= live_thr_q;
              sh_min_q <= live_min_q;
              sh_max_q <= live_max_q;
            end
            default: pend_code_q <= RESP_BAD_ADDR;
          endcase
        end
        APPLY: begin
          live_thr_q     <= sh_thr_q;
          live_min_q     <= sh_min_q;
          live_max_q     <= sh_max_q;
          cfg_update_q   <= 1'b1;
          commit_count_q <= commit_count_q + 16'd1;
          pend_code_q    <= RESP_OK;
          state_q        <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b1;
          resp_code_q  <= pend_code_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Readback sees register contents from before the sampling edge.
  always_comb begin
    rd_data_d = '0;
    unique case (bus.rd_addr)
      3'd0:    rd_data_d = live_thr_q;
      3'd1:    rd_data_d = live_min_q;
      3'd2:    rd_data_d = live_max_q;
      3'd4:    rd_data_d = sh_thr_q;
      3'd5:    rd_data_d = sh_min_q;
      3'd6:    rd_data_d = sh_max_q;
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= bus.rd_valid;
      if (bus.rd_valid) rd_data_q <= rd_data_d;
    end
  end

  assign bus.wr_ready      = (state_q == IDLE) && !reset_i;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_code     = resp_code_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_data_valid_q;

  assign trading_threshold_o = live_thr_q;
  assign risk_min_o          = live_min_q;
  assign risk_max_o          = live_max_q;
  assign cfg_update_o        = cfg_update_q;
  assign commit_count_o      = commit_count_q;

endmodule

// File: tb/tb_config_update_port.sv
// Scoreboard bench for config_update_port: expected responses are queued when a
// request is accepted and compared against responses captured from the bus.
module tb_config_update_port;
  localparam int DATA_W = 32;
  localparam logic [1:0] OK = 2'd0, BAD = 2'd1, CHK = 2'd2;

  typedef struct {
    int         cyc;
    logic [1:0] code;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DATA_W-1:0] thr, rmin, rmax;
  logic cfg_update;
  logic [15:0] commit_count;

  config_update_port_if #(.DATA_W(DATA_W)) bus ();

  config_update_port #(.DATA_W(DATA_W)) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .bus                (bus),
    .trading_threshold_o(thr),
    .risk_min_o         (rmin),
    .risk_max_o         (rmax),
    .cfg_update_o       (cfg_update),
    .commit_count_o     (commit_count)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  int    cfg_cnt = 0;
  int    cfg_cyc = -1;
  resp_t exp_q[$];
  resp_t got_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture responses and update pulses just after each edge, tagged with edge number.
  always @(posedge clk) begin
    #1;
    if (bus.resp_valid === 1'b1) got_q.push_back('{cyc: cyc, code: bus.resp_code});
    if (cfg_update === 1'b1) begin
      cfg_cnt++;
      cfg_cyc = cyc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Present a request until accepted; returns the accept edge number.
  task automatic issue(input logic [2:0] addr, input logic [DATA_W-1:0] data, output int k);
    int budget;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = addr;
    bus.wr_data  = data;
    budget = 0;
    while (bus.wr_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    n_vec++;
    if (budget >= 20) begin
      n_err++;
      $display("FAIL accept_timeout: wr_ready=%b after %0d cycles, expected 1", bus.wr_ready, budget);
    end
    k = cyc + 1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic get_resp(output resp_t r, output bit ok);
    r.cyc  = -1;
    r.code = 2'bxx;
    ok     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (got_q.size() > 0) begin
        r  = got_q.pop_front();
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [2:0] addr, output logic [DATA_W-1:0] data, output logic valid);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = addr;
    @(negedge clk);
    bus.rd_valid = 1'b0;
    data  = bus.rd_data;
    valid = bus.rd_data_valid;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    n_vec++;
    if (bus.wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_in_reset: wr_ready=%b, expected 0", bus.wr_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (thr !== 32'd1000 || rmin !== 32'd1000 || rmax !== 32'd5000) begin
      n_err++;
      $display("FAIL reset_live: got %0d/%0d/%0d, expected 1000/1000/5000", thr, rmin, rmax);
    end
    n_vec++;
    if (bus.wr_ready !== 1'b1 || commit_count !== 16'd0 || cfg_update !== 1'b0 ||
        bus.resp_valid !== 1'b0 || bus.resp_code !== 2'd0 || bus.rd_data_valid !== 1'b0 ||
        bus.rd_data !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: ready=%b count=%0d cfg=%b resp_v=%b code=%0d rd_v=%b rd=%0d, expected 1/0/0/0/0/0/0",
               bus.wr_ready, commit_count, cfg_update, bus.resp_valid, bus.resp_code,
               bus.rd_data_valid, bus.rd_data);
    end
  endtask

  task automatic test_commit();
    logic [2:0]        wa[3] = '{3'd1, 3'd2, 3'd0};
    logic [DATA_W-1:0] wd[3] = '{32'd2000, 32'd8000, 32'd1500};
    int k, c0;
    resp_t e, r;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      issue(wa[i], wd[i], k);
      exp_q.push_back('{cyc: k + 2, code: OK});
      e = exp_q.pop_front();
      get_resp(r, ok);
      n_vec++;
      if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL write_resp[%0d]: code %0d at edge %0d, expected code %0d at edge %0d",
                 i, r.code, r.cyc, e.code, e.cyc);
      end
      n_vec++;
      if (thr !== 32'd1000 || rmin !== 32'd1000 || rmax !== 32'd5000) begin
        n_err++;
        $display("FAIL live_after_write[%0d]: got %0d/%0d/%0d, expected 1000/1000/5000", i, thr, rmin, rmax);
      end
    end
    for (int n = 1; n <= 2; n++) begin
      c0 = cfg_cnt;
      issue(3'd3, '0, k);
      exp_q.push_back('{cyc: k + 3, code: OK});
      e = exp_q.pop_front();
      get_resp(r, ok);
      n_vec++;
      if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL commit_resp[%0d]: code %0d at edge %0d, expected code %0d at edge %0d",
                 n, r.code, r.cyc, e.code, e.cyc);
      end
      n_vec++;
      if (cfg_cnt !== c0 + 1 || cfg_cyc !== k + 2) begin
        n_err++;
        $display("FAIL commit_cfg_update[%0d]: %0d pulses last at edge %0d, expected 1 at edge %0d",
                 n, cfg_cnt - c0, cfg_cyc, k + 2);
      end
      n_vec++;
      if (thr !== 32'd1500 || rmin !== 32'd2000 || rmax !== 32'd8000 || commit_count !== 16'(n)) begin
        n_err++;
        $display("FAIL commit_live[%0d]: got %0d/%0d/%0d count %0d, expected 1500/2000/8000 count %0d",
                 n, thr, rmin, rmax, commit_count, n);
      end
    end
  endtask

  task automatic test_check_fail();
    logic [2:0]        ra[3] = '{3'd4, 3'd5, 3'd6};
    logic [DATA_W-1:0] rx[3] = '{32'd1000, 32'd1000, 32'd5000};
    logic [DATA_W-1:0] d;
    logic v;
    int k, c0;
    resp_t e, r;
    bit ok;
    do_reset();
    c0 = cfg_cnt;
    issue(3'd1, 32'd6000, k);
    exp_q.push_back('{cyc: k + 2, code: OK});
    issue(3'd3, '0, k);
    exp_q.push_back('{cyc: k + 2, code: CHK});
    issue(3'd4, 32'hFFFF_FFFF, k);
    exp_q.push_back('{cyc: k + 2, code: OK});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_resp(r, ok);
      n_vec++;
      if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL check_fail_resp: code %0d at edge %0d, expected code %0d at edge %0d",
                 r.code, r.cyc, e.code, e.cyc);
      end
    end
    n_vec++;
    if (cfg_cnt !== c0 || thr !== 32'd1000 || rmin !== 32'd1000 || rmax !== 32'd5000 || commit_count !== 16'd0) begin
      n_err++;
      $display("FAIL check_fail_live: cfg pulses %0d live %0d/%0d/%0d count %0d, expected 0 1000/1000/5000 0",
               cfg_cnt - c0, thr, rmin, rmax, commit_count);
    end
    for (int i = 0; i < 3; i++) begin
      rd(ra[i], d, v);
      n_vec++;
      if (v !== 1'b1 || d !== rx[i]) begin
        n_err++;
        $display("FAIL abort_shadow_rd[%0d]: valid %b data %0d, expected 1 %0d", ra[i], v, d, rx[i]);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [DATA_W-1:0] d;
    logic v;
    int k;
    resp_t e, r;
    bit ok;
    do_reset();
    issue(3'd6, 32'hDEAD_BEEF, k);
    exp_q.push_back('{cyc: k + 2, code: BAD});
    issue(3'd7, 32'h0000_0001, k);
    exp_q.push_back('{cyc: k + 2, code: BAD});
    issue(3'd5, 32'd42, k);
    exp_q.push_back('{cyc: k + 2, code: BAD});
    issue(3'd0, 32'd0, k);
    exp_q.push_back('{cyc: k + 2, code: OK});
    issue(3'd3, '0, k);
    exp_q.push_back('{cyc: k + 2, code: CHK});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_resp(r, ok);
      n_vec++;
      if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL bad_addr_resp: code %0d at edge %0d, expected code %0d at edge %0d",
                 r.code, r.cyc, e.code, e.cyc);
      end
    end
    rd(3'd6, d, v);
    n_vec++;
    if (v !== 1'b1 || d !== 32'd5000) begin
      n_err++;
      $display("FAIL bad_addr_shadow_max: valid %b data %0d, expected 1 5000", v, d);
    end
    rd(3'd4, d, v);
    n_vec++;
    if (v !== 1'b1 || d !== 32'd0) begin
      n_err++;
      $display("FAIL zero_thr_shadow: valid %b data %0d, expected 1 0", v, d);
    end
    rd(3'd7, d, v);
    n_vec++;
    if (v !== 1'b1 || d !== 32'd0) begin
      n_err++;
      $display("FAIL invalid_rd_addr: valid %b data %0d, expected 1 0", v, d);
    end
    n_vec++;
    if (thr !== 32'd1000 || commit_count !== 16'd0) begin
      n_err++;
      $display("FAIL zero_thr_live: thr %0d count %0d, expected 1000 0", thr, commit_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] d;
    logic v;
    int k, last_k, n_acc;
    bit prev_rd;
    resp_t e, r;
    bit ok;
    do_reset();
    last_k  = -1;
    n_acc   = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (prev_rd) begin
        n_vec++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 32'd1000) begin
          n_err++;
          $display("FAIL b2b_rd[%0d]: valid %b data %0d, expected 1 1000", i, bus.rd_data_valid, bus.rd_data);
        end
      end
      if (i < 10) begin
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 3'd0;
        bus.wr_data  = DATA_W'(100 + i);
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 3'd0;
        prev_rd      = 1'b1;
        if (bus.wr_ready === 1'b1) begin
          k = cyc + 1;
          exp_q.push_back('{cyc: k + 2, code: OK});
          if (last_k >= 0) begin
            n_vec++;
            if (k - last_k !== 3) begin
              n_err++;
              $display("FAIL b2b_spacing: accepts %0d edges apart, expected 3", k - last_k);
            end
          end
          last_k = k;
          n_acc++;
        end
      end else begin
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;
        prev_rd      = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++;
    if (n_acc !== 4) begin
      n_err++;
      $display("FAIL b2b_accepts: %0d accepts, expected 4", n_acc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      get_resp(r, ok);
      n_vec++;
      if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
        n_err++;
        $display("FAIL b2b_resp: code %0d at edge %0d, expected code %0d at edge %0d",
                 r.code, r.cyc, e.code, e.cyc);
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (got_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_extra_resp: %0d unexpected responses, expected 0", got_q.size());
    end
    rd(3'd4, d, v);
    n_vec++;
    if (v !== 1'b1 || d !== 32'd109) begin
      n_err++;
      $display("FAIL b2b_last_shadow: valid %b data %0d, expected 1 109", v, d);
    end
  endtask

  task automatic test_reset_apply();
    int k, c0;
    resp_t e, r;
    bit ok;
    do_reset();
    issue(3'd0, 32'd1500, k);
    exp_q.push_back('{cyc: k + 2, code: OK});
    e = exp_q.pop_front();
    get_resp(r, ok);
    n_vec++;
    if (!ok || r.code !== e.code || r.cyc !== e.cyc) begin
      n_err++;
      $display("FAIL pre_apply_resp: code %0d at edge %0d, expected code %0d at edge %0d",
               r.code, r.cyc, e.code, e.cyc);
    end
    c0 = cfg_cnt;
    issue(3'd3, '0, k);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (got_q.size() !== 0 || cfg_cnt !== c0) begin
      n_err++;
      $display("FAIL apply_reset_pulses: %0d resp %0d cfg_update, expected 0 0", got_q.size(), cfg_cnt - c0);
    end
    n_vec++;
    if (thr !== 32'd1000 || rmin !== 32'd1000 || rmax !== 32'd5000 || commit_count !== 16'd0 ||
        bus.wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL apply_reset_live: %0d/%0d/%0d count %0d ready %b, expected 1000/1000/5000 0 1",
               thr, rmin, rmax, commit_count, bus.wr_ready);
    end
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_commit();
    test_check_fail();
    test_bad_addr();
    test_back_to_back();
    test_reset_apply();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/config_update_port.md
Name: config_update_port

Overview:
- Write side of the trading/risk configuration registers.
- Accepts host register writes over a valid/ready handshake into shadow registers.
- A commit command validates the shadow set and applies it atomically to the live trading_threshold/risk_min/risk_max outputs used by the strategy and risk blocks.
- Also provides a registered readback port for the live and shadow values.

Parameters:
- DATA_W, 32, width of every config register and of wr_data/rd_data.
- DEF_THRESHOLD, 1000, reset value of live and shadow trading threshold.
- DEF_RISK_MIN, 1000, reset value of live and shadow risk_min.
- DEF_RISK_MAX, 5000, reset value of live and shadow risk_max.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  block can accept a request.
- wr_addr  in  3  0=shadow threshold, 1=shadow risk_min, 2=shadow risk_max, 3=COMMIT, 4=ABORT, 5-7 invalid.
- wr_data  in  DATA_W  write data; ignored for COMMIT/ABORT.
- resp_valid  out  1  one-cycle completion pulse per accepted request.
- resp_code  out  2  0=OK, 1=BAD_ADDR, 2=CHECK_FAIL.
- rd_valid  in  1  readback request.
- rd_addr  in  3  0-2 live regs, 4-6 shadow regs (same order), 3/7 invalid.
- rd_data  out  DATA_W  readback data.
- rd_data_valid  out  1  rd_data qualifier.
- trading_threshold  out  DATA_W  live threshold.
- risk_min  out  DATA_W  live lower risk limit.
- risk_max  out  DATA_W  live upper risk limit.
- cfg_update  out  1  one-cycle pulse when the live registers change.
- commit_count  out  16  number of successful commits; wraps 0xFFFF->0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values:
  - Live and shadow registers take their DEF_* values.
  - State=IDLE.
  - resp_valid, resp_code, cfg_update, rd_data, rd_data_valid and commit_count are all 0.
- wr_ready = (state==IDLE) && !reset. The request is accepted on the edge where wr_valid && wr_ready; call that edge k. addr/data are latched at k.
- FSM states: IDLE, EXEC, APPLY, RESP.
  - IDLE -> EXEC on accept.
  - EXEC, addr 0-2: write latched data to that shadow reg at edge k+1; -> RESP with code OK.
  - EXEC, addr 4 (ABORT): copy live regs into shadows at k+1; -> RESP, OK.
  - EXEC, addr 5-7: no register change; -> RESP, BAD_ADDR.
  - EXEC, addr 3 (COMMIT): check shadow_risk_min <= shadow_risk_max (unsigned) AND shadow_threshold != 0.
    - Pass -> APPLY.
    - Fail -> RESP, CHECK_FAIL, live regs untouched.
  - APPLY: at the edge leaving APPLY (k+2), all three live regs take the shadow values simultaneously, cfg_update=1 for exactly one cycle, and commit_count increments; -> RESP, OK.
  - RESP: resp_valid=1 and resp_code valid for exactly one cycle; -> IDLE.
- Latency from accept edge k:
  - Shadow write, ABORT, BAD_ADDR and CHECK_FAIL: resp_valid registered high at edge k+2.
  - Successful commit: live values and cfg_update registered at k+2; resp_valid registered high at k+3.
  - The next accept is earliest at edge k+3 (k+4 after a successful commit).
- resp_code holds its last value when resp_valid=0.
- Only one request is in flight at a time. wr_valid may stay high; it is not sampled while wr_ready=0.
- Live registers change only via a successful commit or reset, never on a shadow write.
- A commit with unchanged shadows is still OK: cfg_update pulses and commit_count increments.
- Readback:
  - Independent of the write FSM and always accepted.
  - rd_valid sampled at edge j gives rd_data_valid=1 and rd_data at edge j+1.
  - Values reflect register contents before edge j.
  - Invalid rd_addr returns rd_data=0 with rd_data_valid=1.
  - Back-to-back reads are supported every cycle.
  - rd_data_valid=0 when there is no request; rd_data then holds its last value.
- Reset mid-operation: in any state, reset returns to IDLE with all outputs at reset values and suppresses any pending resp_valid or cfg_update. A commit in APPLY is discarded.

Test Plan:
- Reset, then idle -> trading_threshold=1000, risk_min=1000, risk_max=5000, wr_ready=1, commit_count=0, cfg_update=0.
- Write addr1=2000, addr2=8000, addr0=1500, then COMMIT -> each write gets resp OK 2 cycles after accept with live regs unchanged; at commit, live=1500/2000/8000, cfg_update pulses once, commit_count=1, resp OK at k+3.
- Write risk_min=6000 (shadow risk_max=5000), COMMIT -> resp CHECK_FAIL at k+2, live unchanged, no cfg_update; then ABORT -> rd_addr 5 returns 1000.
- Write addr 6 and 7 -> BAD_ADDR, no register change; threshold shadow=0 then COMMIT -> CHECK_FAIL.
- wr_valid held high for 10 cycles with writes -> each accept only in IDLE, one resp per accept; concurrent rd_valid every cycle on addr 0 returns data 1 cycle later.
- Assert reset during APPLY of a commit -> no cfg_update, no resp_valid, live regs = 1000/1000/5000, commit_count=0.
